// File: rtl/fetch_queue_unit_if.sv
// Fetch-stage bundle: redirect, ICache, predictor and decoder-side handshake.
// The master modport is the fetch unit; slave is its environment.
interface fetch_queue_unit_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               icache_req;
  logic [ADDR_W-1:0]  icache_addr;
  logic [INSTR_W-1:0] icache_data;
  logic               icache_success;
  logic [ADDR_W-1:0]  pred_pc;
  logic               pred_taken;
  logic               dec_valid;
  logic [INSTR_W-1:0] dec_instr;
  logic [ADDR_W-1:0]  dec_pc;
  logic               dec_pred_taken;
  logic               dec_ready;
  logic [CW-1:0]      q_count;

  modport master (
    input  redirect_valid, redirect_pc, icache_data, icache_success,
           pred_taken, dec_ready,
    output icache_req, icache_addr, pred_pc, dec_valid, dec_instr,
           dec_pc, dec_pred_taken, q_count
  );

  modport slave (
    output redirect_valid, redirect_pc, icache_data, icache_success,
           pred_taken, dec_ready,
    input  icache_req, icache_addr, pred_pc, dec_valid, dec_instr,
           dec_pc, dec_pred_taken, q_count
  );
endinterface

// File: rtl/fetch_queue_unit.sv
// Instruction fetch stage: single outstanding ICache request, local JAL/branch
// next-PC prediction and a DEPTH-entry queue to the decoder. Optional
// FETCH_QUEUE_BYPASS_EN forwards a response straight to an idle decoder.
module fetch_queue_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter int                DEPTH    = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic                clk,
  input logic                rst_n,
  input logic                rdy,
  fetch_queue_unit_if.master bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
    logic               pt;
  } entry_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_req;

  entry_t            mem [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr, rd_ptr_nx, wr_ptr_nx;
  logic [CW-1:0]     count, count_nx;
  entry_t            head_q, head_nx;
  logic              head_valid_q;

  logic [6:0]        opcode;
  logic [ADDR_W-1:0] j_off, b_off, next_pc;
  logic              taken;
  entry_t            new_entry;
  logic              fetched, bypass, enq, deq;

  assign opcode = bus.icache_data[6:0];
  assign j_off  = {{(ADDR_W-20){bus.icache_data[31]}}, bus.icache_data[19:12],
                   bus.icache_data[20], bus.icache_data[30:21], 1'b0};
  assign b_off  = {{(ADDR_W-12){bus.icache_data[31]}}, bus.icache_data[7],
                   bus.icache_data[30:25], bus.icache_data[11:8], 1'b0};

  always_comb begin
    taken   = 1'b0;
    next_pc = pc + ADDR_W'(4);
    case (opcode)
      7'b1101111: begin
        taken   = 1'b1;
        next_pc = pc + j_off;
      end
      7'b1100011: begin
        taken = bus.pred_taken;
        if (bus.pred_taken) next_pc = pc + b_off;
      end
      default: ;
    endcase
  end

  assign new_entry = '{instr: bus.icache_data, pc: pc, pt: taken};
  assign fetched   = rdy && (state == WAIT) && bus.icache_success && !bus.redirect_valid;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = fetched && (count == '0) && bus.dec_ready;
`else
  assign bypass = 1'b0;
`endif

  assign enq       = fetched && !bypass;
  assign deq       = rdy && head_valid_q && bus.dec_ready && !bus.redirect_valid;
  assign rd_ptr_nx = deq ? rd_ptr + PW'(1) : rd_ptr;
  assign wr_ptr_nx = enq ? wr_ptr + PW'(1) : wr_ptr;

  always_comb begin
    count_nx = count;
    if (enq && !deq)      count_nx = count + CW'(1);
    else if (deq && !enq) count_nx = count - CW'(1);
  end

  // Head is registered: when the queue drains to nothing this cycle, the
  // incoming entry is not yet in mem, so it is taken from the response.
  always_comb begin
    head_nx = '0;
    if (count_nx != '0) begin
      if ((count == '0) || ((count == CW'(1)) && deq)) head_nx = new_entry;
      else                                             head_nx = mem[rd_ptr_nx];
    end
  end

  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= new_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      fetch_addr   <= RESET_PC;
      fetch_req    <= 1'b0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      head_q       <= '0;
      head_valid_q <= 1'b0;
    end else if (rdy) begin
      if (bus.redirect_valid) begin
        pc           <= bus.redirect_pc;
        rd_ptr       <= '0;
        wr_ptr       <= '0;
        count        <= '0;
        head_q       <= '0;
        head_valid_q <= 1'b0;
      end else begin
        if (fetched) pc <= next_pc;
        rd_ptr       <= rd_ptr_nx;
        wr_ptr       <= wr_ptr_nx;
        count        <= count_nx;
        head_q       <= head_nx;
        head_valid_q <= (count_nx != '0);
      end

      case (state)
        IDLE: begin
          if (!bus.redirect_valid && (count < CW'(DEPTH))) begin
            fetch_req  <= 1'b1;
            fetch_addr <= pc;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (bus.icache_success) begin
            fetch_req <= 1'b0;
            state     <= IDLE;
          end else if (bus.redirect_valid) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (bus.icache_success) begin
            fetch_req <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.icache_req     = fetch_req;
  assign bus.icache_addr    = fetch_addr;
  assign bus.pred_pc        = fetch_addr;
  assign bus.q_count        = count;
  assign bus.dec_valid      = head_valid_q | bypass;
  assign bus.dec_instr      = bypass ? new_entry.instr : head_q.instr;
  assign bus.dec_pc         = bypass ? new_entry.pc    : head_q.pc;
  assign bus.dec_pred_taken = bypass ? new_entry.pt    : head_q.pt;
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: directed scenarios followed by randomized traffic,
// all checked against a transaction-level queue/PC model.
module tb_fetch_queue_unit;
  localparam int          AW    = 32;
  localparam int          IW    = 32;
  localparam int          DEPTH = 8;
  localparam logic [31:0] RPC   = 32'h100;
  localparam logic [31:0] ADDI  = 32'h0010_0093;
  localparam logic [31:0] JAL20 = 32'h0200_00EF;
  localparam logic [31:0] BEQM8 = 32'hFE00_0CE3;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        pt;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic rdy = 1'b1;
  always #5 clk = ~clk;

  fetch_queue_unit_if #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(DEPTH)) bus ();

  fetch_queue_unit #(
    .ADDR_W(AW), .INSTR_W(IW), .DEPTH(DEPTH), .RESET_PC(RPC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [31:0] m_pc, m_addr;
  bit          m_req, m_out, m_stale;
  ent_t        m_q[$];

  // ICache / environment driver state
  logic [31:0] imem [logic [31:0]];
  bit          pmap [logic [31:0]];
  bit          answered = 0, prev_req = 0, rand_mode = 0, force_succ = 0;
  bit          redir_on_wait = 0, redir_on_resp = 0;
  logic [31:0] hook_pc = '0;
  int          lat_cnt = 0, lat_lo = 1, lat_hi = 1;
  bit          nx_rst_n = 1, nx_rdy = 1, nx_ready = 1, nx_redir = 0;
  logic [31:0] nx_rpc = '0;
  logic [31:0] issued[$];
  ent_t        act_deq[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] d,
                                             input bit pt, output bit tk);
    longint off;
    off = 4;
    tk  = 0;
    if (d[6:0] == 7'h6F) begin
      tk  = 1;
      off = longint'({d[31], d[19:12], d[20], d[30:21], 1'b0});
      if (d[31]) off = off - (longint'(1) << 21);
    end else if (d[6:0] == 7'h63) begin
      tk = pt;
      if (pt) begin
        off = longint'({d[31], d[7], d[30:25], d[11:8], 1'b0});
        if (d[31]) off = off - (longint'(1) << 13);
      end
    end
    return pc + off[31:0];
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom();
    case ($urandom_range(0, 4))
      0: w[6:0] = 7'h6F;
      1: w[6:0] = 7'h63;
      2: w[6:0] = 7'h13;
      3: w[6:0] = 7'h67;
      default: ;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] iss(input int i);
    return (i < issued.size()) ? issued[i] : 'x;
  endfunction

  function automatic ent_t deq_at(input int i);
    ent_t e;
    e = 'x;
    if (i < act_deq.size()) e = act_deq[i];
    return e;
  endfunction

  task automatic model_reset();
    m_pc = RPC; m_addr = RPC; m_req = 0; m_out = 0; m_stale = 0;
    m_q.delete();
  endtask

  task automatic model_update();
    int   sz;
    bit   tk;
    ent_t e;
    if (!rst_n || !rdy) return;
    sz = m_q.size();
    if (bus.redirect_valid) begin
      m_q.delete();
      m_pc = bus.redirect_pc;
      if (m_out && bus.icache_success) begin
        m_out = 0; m_stale = 0; m_req = 0;
      end else if (m_out) begin
        m_stale = 1;
      end
    end else begin
      if (sz > 0 && bus.dec_ready) void'(m_q.pop_front());
      if (m_out) begin
        if (bus.icache_success) begin
          if (!m_stale) begin
            e.instr = bus.icache_data;
            e.pc    = m_pc;
            m_pc    = model_next(m_pc, bus.icache_data, bus.pred_taken, tk);
            e.pt    = tk;
            m_q.push_back(e);
          end
          m_out = 0; m_stale = 0; m_req = 0;
        end
      end else if (sz < DEPTH) begin
        m_out = 1; m_req = 1; m_addr = m_pc;
      end
    end
  endtask

  task automatic check_outputs();
    chk("icache_req", bus.icache_req, m_req);
    chk("icache_addr", bus.icache_addr, m_addr);
    chk("pred_pc", bus.pred_pc, m_addr);
    chk("q_count", bus.q_count, m_q.size());
    chk("dec_valid", bus.dec_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      chk("dec_instr", bus.dec_instr, m_q[0].instr);
      chk("dec_pc", bus.dec_pc, m_q[0].pc);
      chk("dec_pred_taken", bus.dec_pred_taken, m_q[0].pt);
    end
  endtask

  task automatic drive_icache();
    bus.icache_data    = $urandom();
    bus.pred_taken     = 1'($urandom_range(0, 1));
    bus.icache_success = 1'b0;
    if (!rdy) return;
    if (force_succ) begin
      bus.icache_success = 1'b1;
      force_succ = 0;
      return;
    end
    if (!bus.icache_req) begin
      answered = 0;
      prev_req = 0;
      lat_cnt  = $urandom_range(lat_lo, lat_hi) - 1;
      return;
    end
    if (!prev_req) begin
      prev_req = 1;
      issued.push_back(bus.icache_addr);
      if (redir_on_wait && lat_cnt > 0) begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = hook_pc;
        redir_on_wait      = 0;
      end
    end
    if (answered) return;
    if (lat_cnt > 0) begin
      lat_cnt--;
      return;
    end
    answered = 1;
    bus.icache_success = 1'b1;
    if (rand_mode) begin
      bus.icache_data = rand_instr();
    end else begin
      bus.icache_data = imem.exists(bus.icache_addr) ? imem[bus.icache_addr] : ADDI;
      bus.pred_taken  = pmap.exists(bus.icache_addr) ? pmap[bus.icache_addr] : 1'b0;
    end
    if (redir_on_resp) begin
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = hook_pc;
      redir_on_resp      = 0;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    rst_n              = nx_rst_n;
    rdy                = nx_rdy;
    bus.dec_ready      = nx_ready;
    bus.redirect_valid = nx_redir;
    bus.redirect_pc    = nx_rpc;
    nx_redir           = 0;
    if (!rst_n) begin
      bus.icache_success = 1'b0;
      answered = 0;
      prev_req = 0;
      model_reset();
      #1;
      chk("rst_icache_req", bus.icache_req, 1'b0);
      chk("rst_icache_addr", bus.icache_addr, RPC);
      chk("rst_q_count", bus.q_count, 0);
      chk("rst_dec_valid", bus.dec_valid, 1'b0);
      chk("rst_dec_instr", bus.dec_instr, 0);
      chk("rst_dec_pc", bus.dec_pc, 0);
      chk("rst_dec_pred_taken", bus.dec_pred_taken, 1'b0);
    end else begin
      drive_icache();
    end
    if (rst_n && rdy && bus.dec_valid && bus.dec_ready && !bus.redirect_valid)
      act_deq.push_back({bus.dec_instr, bus.dec_pc, bus.dec_pred_taken});
    @(posedge clk);
    model_update();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic redirect_to(input logic [31:0] a);
    nx_redir = 1;
    nx_rpc   = a;
    cycle();
    issued.delete();
    act_deq.delete();
  endtask

  initial begin
    bus.redirect_valid = 0; bus.redirect_pc = '0; bus.icache_data = '0;
    bus.icache_success = 0; bus.pred_taken = 0; bus.dec_ready = 1;
    #1 rst_n = 1'b0;
    model_reset();
    nx_rst_n = 0;
    run(2);

    // sequential ADDI stream from RESET_PC; spurious success while idle is ignored
    nx_rst_n = 1;
    force_succ = 1;
    run(12);
    chk("seq_addr0", iss(0), 32'h100);
    chk("seq_addr1", iss(1), 32'h104);
    chk("seq_addr2", iss(2), 32'h108);
    chk("seq_dec_pc0", deq_at(0).pc, 32'h100);
    chk("seq_dec_pc1", deq_at(1).pc, 32'h104);
    chk("seq_dec_pc2", deq_at(2).pc, 32'h108);
    chk("seq_dec_pt", deq_at(0).pt | deq_at(1).pt | deq_at(2).pt, 1'b0);

    // JAL +0x20 then BEQ -8, predicted taken and not taken
    imem[32'h100] = JAL20;
    imem[32'h120] = BEQM8;
    pmap[32'h120] = 1'b1;
    redirect_to(32'h100);
    run(12);
    chk("jal_target", iss(1), 32'h120);
    chk("jal_pt", deq_at(0).pt, 1'b1);
    chk("jal_dec_pc", deq_at(0).pc, 32'h100);
    chk("beq_taken_target", iss(2), 32'h118);
    chk("beq_taken_pt", deq_at(1).pt, 1'b1);
    pmap[32'h120] = 1'b0;
    redirect_to(32'h120);
    run(8);
    chk("beq_nt_first", iss(0), 32'h120);
    chk("beq_nt_target", iss(1), 32'h124);
    chk("beq_nt_pt", deq_at(0).pt, 1'b0);

    // decoder stall fills the queue; release dequeues one per cycle
    nx_ready = 0;
    run(30);
    #1;
    chk("full_q_count", bus.q_count, DEPTH);
    chk("full_no_req", bus.icache_req, 1'b0);
    nx_ready = 1;
    cycle();
    #1;
    chk("drain1_q_count", bus.q_count, DEPTH - 1);
    chk("drain1_no_req", bus.icache_req, 1'b0);
    cycle();
    #1;
    chk("resume_req", bus.icache_req, 1'b1);
    chk("resume_q_count", bus.q_count, DEPTH - 2);
    run(20);

    // redirect while waiting on a 3-cycle response
    lat_lo = 3; lat_hi = 3;
    hook_pc = 32'h400;
    redir_on_wait = 1;
    for (int i = 0; i < 20 && redir_on_wait; i++) cycle();
    chk("wait_redirect_fired", redir_on_wait, 1'b0);
    #1;
    chk("wait_redirect_q_count", bus.q_count, 0);
    chk("wait_redirect_dec_valid", bus.dec_valid, 1'b0);
    issued.delete();
    run(10);
    chk("wait_redirect_next", iss(0), 32'h400);

    // redirect coinciding with the response
    lat_lo = 1; lat_hi = 1;
    run(4);
    redir_on_resp = 1;
    for (int i = 0; i < 20 && redir_on_resp; i++) cycle();
    chk("resp_redirect_fired", redir_on_resp, 1'b0);
    #1;
    chk("resp_redirect_q_count", bus.q_count, 0);
    issued.delete();
    run(6);
    chk("resp_redirect_next", iss(0), 32'h400);

    // address wrap
    redirect_to(32'hFFFF_FFFC);
    run(8);
    chk("wrap_first", iss(0), 32'hFFFF_FFFC);
    chk("wrap_next", iss(1), 32'h0);

    // reset mid-WAIT, then rdy freeze with a partly full queue
    lat_lo = 3; lat_hi = 3;
    run(2);
    for (int i = 0; i < 10 && !m_out; i++) cycle();
    chk("pre_reset_outstanding", bus.icache_req, 1'b1);
    nx_rst_n = 0;
    cycle();
    nx_rst_n = 1;
    issued.delete();
    run(8);
    chk("reset_restart", iss(0), RPC);
    nx_ready = 0;
    run(9);
    nx_rdy = 0;
    run(5);
    nx_rdy = 1;
    nx_ready = 1;
    run(10);

    // randomized traffic
    rand_mode = 1;
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 3000; i++) begin
      nx_ready = ($urandom_range(0, 9) < 7);
      nx_rdy   = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 49) == 0) begin
        nx_redir = 1;
        nx_rpc   = $urandom() & 32'hFFFF_FFFC;
      end
      cycle();
    end
    nx_rdy = 1;
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
